// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - stage-by-stage sequencer for a radix-2 FFT pass
//
// Launches the stage datapath once per stage, waits for its completion strobe,
// inserts a settle gap, tracks the ping-pong bank and guards each stage with a
// watchdog.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_go         start a new pass (honoured in IDLE and ERROR only)
//   i_abort      synchronous abort, highest priority in every state
//   i_stage_done datapath stage-complete strobe (honoured in WAIT only)
//   o_start      one-cycle launch pulse to the datapath
//   o_stage      current stage index
//   o_bank       ping-pong bank select (read = o_bank, write = ~o_bank)
//   o_busy       high in LAUNCH, WAIT, GAP, FINISH
//   o_done       one-cycle pass-complete pulse
//   o_err        sticky stage-timeout flag

module fft_stage_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int STAGE_W    = 3,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_go,
  input  logic               i_abort,
  input  logic               i_stage_done,
  output logic               o_start,
  output logic [STAGE_W-1:0] o_stage,
  output logic               o_bank,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [WD_W-1:0]    WD_MAX     = WD_W'(TIMEOUT - 1);
  localparam logic [3:0]         GAP_LAST   = 4'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_GAP,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WD_W-1:0] wd_cnt;
  logic [3:0]      gap_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (i_go) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        // A completion on the expiry cycle still counts as a completion.
        if (i_stage_done) begin
          state_next = (o_stage == LAST_STAGE) ? S_FINISH : S_GAP;
        end else if (wd_cnt == WD_MAX) begin
          state_next = S_ERROR;
        end
      end
      S_GAP:    if (gap_cnt == GAP_LAST) state_next = S_LAUNCH;
      S_FINISH: state_next = S_IDLE;
      S_ERROR:  if (i_go) state_next = S_LAUNCH;
      default:  state_next = S_IDLE;
    endcase
    if (i_abort) state_next = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_start <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
      o_stage <= '0;
      o_bank  <= 1'b0;
      wd_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      o_start <= (state_next == S_LAUNCH);
      o_busy  <= (state_next == S_LAUNCH) || (state_next == S_WAIT) ||
                 (state_next == S_GAP)    || (state_next == S_FINISH);
      o_done  <= (state_next == S_FINISH);
      o_err   <= (state_next == S_ERROR);

      if (state == S_LAUNCH) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT && wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end

      gap_cnt <= (state == S_GAP) ? gap_cnt + 4'd1 : 4'd0;

      // Stage and bank advance on the last gap cycle so the new values are
      // already present in the following LAUNCH cycle.
      if (i_abort || ((state == S_IDLE || state == S_ERROR) && i_go)) begin
        o_stage <= '0;
        o_bank  <= 1'b0;
      end else if (state == S_GAP && gap_cnt == GAP_LAST && o_stage != LAST_STAGE) begin
        o_stage <= o_stage + STAGE_W'(1);
        o_bank  <= ~o_bank;
      end
    end
  end

endmodule
